ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Reset is synchronous and active-high; one clock; ports CLK, RST.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 ex_valid  input  1  EX holds a real instruction.
REQ-005 ex_rd, ex_rt  input  5 each  destination reg; rt field.
REQ-006 ex_regwr, ex_memrd, ex_memwr, ex_halt  input  1 each  register write; load; store; halt.
REQ-007 ex_aluout, ex_store  input  32 each  ALU result/address; store data.
REQ-008 flush  input  1  replace the incoming capture with a bubble.
REQ-009 dhit  input  1  data memory completes the request this cycle.
REQ-010 dload  input  32  load data, valid with dhit.
REQ-011 dmem_ren, dmem_wen  output  1 each  memory read/write request.
REQ-012 dmem_addr, dmem_store  output  32 each  request address; store data.
REQ-013 rd_mem, mem_rt  output  5 each  latched rd and rt, to forwarding logic.
REQ-014 wr_mem, wm_mem  output  1 each  latched regwr and memwr, valid-qualified.
REQ-015 mem_stall  output  1  freeze upstream stages and PC.
REQ-016 wb_valid, wb_regwr  output  1 each  MEM/WB latch valid; register write.
REQ-017 wb_rd  output  5  MEM/WB destination register.
REQ-018 wb_data  output  32  MEM/WB write-back data.
REQ-019 halt_out  output  1  halt has reached MEM; sticky.
REQ-020 stall_cycles  output  16  memory-wait stall cycle count.

Function
REQ-021 Stage latch L captures valid, rd, rt, regwr, memrd, memwr, halt, aluout and store on every edge where mem_stall=0.
- flush=1 at that edge: L.valid=0; regwr, memrd, memwr and halt are 0.
- Otherwise: L.valid=ex_valid; all control bits are ANDed with ex_valid.
REQ-022 flush is sampled only on advancing edges; it is ignored while mem_stall=1.
REQ-023 The FSM has states RUN, WAIT and HALT.
REQ-024 RUN -> WAIT when L.valid and (L.memrd or L.memwr) and dhit=0 in that cycle.
REQ-025 WAIT -> RUN on dhit=1.
REQ-026 Any state -> HALT when L.valid and L.halt; HALT is left only by RST.
REQ-027 dmem_ren=L.valid&L.memrd and dmem_wen=L.valid&L.memwr, asserted in RUN and WAIT, never in HALT.
- dmem_addr=L.aluout; dmem_store=L.store.
- All four are held stable for the whole WAIT.
REQ-028 mem_stall=(dmem_ren|dmem_wen)&~dhit, or 1 in HALT.
- A memory op hit in its first cycle causes zero stall.
REQ-029 rd_mem=L.rd, mem_rt=L.rt, wr_mem=L.valid&L.regwr, wm_mem=L.valid&L.memwr.
- These stay stable while stalled.
REQ-030 MEM/WB latch updates every edge.
- mem_stall=0: wb_valid=L.valid, wb_regwr=L.valid&L.regwr, wb_rd=L.rd, wb_data=L.memrd?dload:L.aluout.
- mem_stall=1: bubble, with wb_valid=0 and wb_regwr=0; wb_rd and wb_data hold.
REQ-031 A store produces wb_regwr=0 regardless of ex_regwr.
REQ-032 stall_cycles increments by 1 each cycle the FSM is in WAIT, or RUN with mem_stall=1.
- Saturates at 0xFFFF; HALT cycles are not counted.
REQ-033 halt_out=1 from the first cycle in HALT until RST.
REQ-034 Back-to-back memory ops: the second enters L only on the dhit edge of the first; no request cycle is dropped or duplicated.

Reset
REQ-035 RST=1 at an edge clears L to a bubble, clears the MEM/WB latch, and sets FSM=RUN, stall_cycles=0, halt_out=0.
REQ-036 Therefore all outputs read 0 in the cycle after reset.
REQ-037 RST mid-WAIT aborts the request; dmem_ren/wen=0 in the next cycle, and a dhit arriving then is ignored.

Verification
REQ-038 Reset, then idle 3 cycles -> every output 0, including stall_cycles=0.
REQ-039 ALU op rd=5, regwr=1, aluout=0x1234 -> next cycle rd_mem=5, wr_mem=1; cycle after: wb_valid=1, wb_rd=5, wb_data=0x1234.
REQ-040 Load rd=8, aluout=0x40, dhit asserted 3 cycles late with dload=0xCAFE ->
- dmem_ren=1, addr=0x40 held 4 cycles;
- mem_stall=1 for 3 cycles and wb_valid=0 for those 3 cycles;
- then wb_data=0xCAFE; stall_cycles=3.
REQ-041 Store rt=9, store=0xBEEF, immediate dhit -> wm_mem=1, mem_rt=9, dmem_wen=1, dmem_store=0xBEEF, mem_stall=0, wb_regwr=0.
REQ-042 flush=1 with a valid ALU op, and flush=1 during a WAIT ->
- first: wr_mem=0 and a bubble follows;
- second: flush ignored, the stalled load completes normally.
REQ-043 Halt op, then 10 cycles of RST=0 -> halt_out=1, mem_stall=1, no dmem requests, stall_cycles unchanged; RST clears all.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: holds the instruction in MEM, drives the data-memory
// request, stalls upstream until the memory completes, and feeds the MEM/WB latch.
module ex_mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex_valid,
  input  logic [4:0]        ex_rd,
  input  logic [4:0]        ex_rt,
  input  logic              ex_regwr,
  input  logic              ex_memrd,
  input  logic              ex_memwr,
  input  logic              ex_halt,
  input  logic [DATA_W-1:0] ex_aluout,
  input  logic [DATA_W-1:0] ex_store,
  input  logic              flush,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dload,
  output logic              dmem_ren,
  output logic              dmem_wen,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_store,
  output logic [4:0]        rd_mem,
  output logic [4:0]        mem_rt,
  output logic              wr_mem,
  output logic              wm_mem,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              wb_regwr,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              halt_out,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

  state_t state_q, state_d;

  logic              l_valid_q, l_valid_d;
  logic [4:0]        l_rd_q, l_rd_d;
  logic [4:0]        l_rt_q, l_rt_d;
  logic              l_regwr_q, l_regwr_d;
  logic              l_memrd_q, l_memrd_d;
  logic              l_memwr_q, l_memwr_d;
  logic              l_halt_q, l_halt_d;
  logic [DATA_W-1:0] l_aluout_q, l_aluout_d;
  logic [DATA_W-1:0] l_store_q, l_store_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_regwr_q, wb_regwr_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [15:0]       stall_q, stall_d;
  logic              req_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign req_ok     = (state_q != S_HALT);
  assign dmem_ren   = req_ok & l_valid_q & l_memrd_q;
  assign dmem_wen   = req_ok & l_valid_q & l_memwr_q;
  assign dmem_addr  = l_aluout_q;
  assign dmem_store = l_store_q;
  assign mem_stall  = ~req_ok | ((dmem_ren | dmem_wen) & ~dhit);

  assign rd_mem       = l_rd_q;
  assign mem_rt       = l_rt_q;
  assign wr_mem       = l_valid_q & l_regwr_q;
  assign wm_mem       = l_valid_q & l_memwr_q;
  assign wb_valid     = wb_valid_q;
  assign wb_regwr     = wb_regwr_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign halt_out     = (state_q == S_HALT);
  assign stall_cycles = stall_q;

  // Stage latch: frozen while stalled, so flush only matters on advancing edges
  always_comb begin
    l_valid_d  = l_valid_q;
    l_rd_d     = l_rd_q;
    l_rt_d     = l_rt_q;
    l_regwr_d  = l_regwr_q;
    l_memrd_d  = l_memrd_q;
    l_memwr_d  = l_memwr_q;
    l_halt_d   = l_halt_q;
    l_aluout_d = l_aluout_q;
    l_store_d  = l_store_q;
    if (!mem_stall) begin
      l_rd_d     = ex_rd;
      l_rt_d     = ex_rt;
      l_aluout_d = ex_aluout;
      l_store_d  = ex_store;
      l_valid_d  = ex_valid & ~flush;
      l_regwr_d  = ex_regwr & ex_valid & ~flush;
      l_memrd_d  = ex_memrd & ex_valid & ~flush;
      l_memwr_d  = ex_memwr & ex_valid & ~flush;
      l_halt_d   = ex_halt  & ex_valid & ~flush;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if ((dmem_ren | dmem_wen) && !dhit) state_d = S_WAIT;
      S_WAIT:  if (dhit) state_d = S_RUN;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
    if (l_valid_q && l_halt_q) state_d = S_HALT;
  end

  // MEM/WB latch: a stall inserts a bubble but keeps rd/data
  always_comb begin
    wb_valid_d = 1'b0;
    wb_regwr_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (!mem_stall) begin
      wb_valid_d = l_valid_q;
      wb_regwr_d = l_valid_q & l_regwr_q & ~l_memwr_q;
      wb_rd_d    = l_rd_q;
      wb_data_d  = l_memrd_q ? dload : l_aluout_q;
    end
  end

  assign stall_d = (req_ok && mem_stall) ? sat_inc(stall_q) : stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_RUN;
      l_valid_q  <= 1'b0;
      l_rd_q     <= '0;
      l_rt_q     <= '0;
      l_regwr_q  <= 1'b0;
      l_memrd_q  <= 1'b0;
      l_memwr_q  <= 1'b0;
      l_halt_q   <= 1'b0;
      l_aluout_q <= '0;
      l_store_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_regwr_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      l_valid_q  <= l_valid_d;
      l_rd_q     <= l_rd_d;
      l_rt_q     <= l_rt_d;
      l_regwr_q  <= l_regwr_d;
      l_memrd_q  <= l_memrd_d;
      l_memwr_q  <= l_memwr_d;
      l_halt_q   <= l_halt_d;
      l_aluout_q <= l_aluout_d;
      l_store_q  <= l_store_d;
      wb_valid_q <= wb_valid_d;
      wb_regwr_q <= wb_regwr_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage: an instruction-level model of the MEM stage
// predicts memory-side outputs each cycle and queues expected MEM/WB results.
module tb_ex_mem_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_rd = '0, ex_rt = '0;
  logic        ex_regwr = 1'b0, ex_memrd = 1'b0, ex_memwr = 1'b0, ex_halt = 1'b0;
  logic [31:0] ex_aluout = '0, ex_store = '0;
  logic        flush = 1'b0, dhit = 1'b0;
  logic [31:0] dload = '0;
  logic        dmem_ren, dmem_wen;
  logic [31:0] dmem_addr, dmem_store;
  logic [4:0]  rd_mem, mem_rt;
  logic        wr_mem, wm_mem, mem_stall, wb_valid, wb_regwr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        halt_out;
  logic [15:0] stall_cycles;

  ex_mem_stage dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rt(ex_rt),
    .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_halt(ex_halt),
    .ex_aluout(ex_aluout), .ex_store(ex_store), .flush(flush), .dhit(dhit), .dload(dload),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_store(dmem_store),
    .rd_mem(rd_mem), .mem_rt(mem_rt), .wr_mem(wr_mem), .wm_mem(wm_mem), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_rd(wb_rd), .wb_data(wb_data),
    .halt_out(halt_out), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic        regwr, memrd, memwr, halt;
    logic [31:0] alu, st, ldata;
    logic [1:0]  lat;
  } instr_t;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic        regwr;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  bit   done = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic instr_t gen(input bit allow_halt);
    instr_t i;
    int k;
    i.valid = ($urandom_range(0, 9) < 8);
    i.rd    = 5'($urandom);
    i.rt    = 5'($urandom);
    i.alu   = $urandom;
    i.st    = $urandom;
    i.ldata = $urandom;
    i.lat   = 2'($urandom_range(0, 3));
    i.regwr = 1'($urandom);
    i.memrd = 1'b0;
    i.memwr = 1'b0;
    i.halt  = 1'b0;
    k = $urandom_range(0, 99);
    if (k < 30) begin
      i.memrd = 1'b1;
      i.regwr = 1'b1;
    end else if (k < 50) begin
      i.memwr = 1'b1;
    end else if (allow_halt && k == 99) begin
      i.halt = 1'b1;
    end
    if (!i.valid && $urandom_range(0, 3) == 0) i.halt = 1'b1;
    return i;
  endfunction

  // Monitor: every cycle either a queued result is due on MEM/WB or a bubble is
  initial begin
    exp_t e;
    wait (mon_on);
    while (!done) begin
      @(negedge CLK);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        vectors++;
        if (wb_valid !== 1'b1 || wb_rd !== e.rd || wb_regwr !== e.regwr || wb_data !== e.data) begin
          miscompares++;
          $display("FAIL wb_out cyc=%0d got v=%b rd=%0d wr=%b data=%h exp v=1 rd=%0d wr=%b data=%h",
                   cyc, wb_valid, wb_rd, wb_regwr, wb_data, e.rd, e.regwr, e.data);
        end
      end else begin
        vectors++;
        if (wb_valid !== 1'b0 || wb_regwr !== 1'b0) begin
          miscompares++;
          $display("FAIL wb_bubble cyc=%0d got v=%b wr=%b exp v=0 wr=0", cyc, wb_valid, wb_regwr);
        end
      end
    end
  end

  initial begin
    localparam int N = 3000;
    instr_t      cur, m_l;
    exp_t        e;
    int          m_cnt, m_stalls, halt_wait;
    bit          m_halted, accepted, fl, do_rst, memop, exp_stall, drain;
    logic [95:0] got, exp_v;

    repeat (2) @(posedge CLK);
    #1;
    m_l = '0; cur = '0; m_cnt = 0; m_stalls = 0; halt_wait = 0;
    m_halted = 1'b0; accepted = 1'b1;
    mon_on = 1'b1;

    for (int c = 0; c < N; c++) begin
      drain  = (c >= N - 20);
      do_rst = (halt_wait >= 10) || (c > 20 && c < N - 30 && $urandom_range(0, 199) == 0);
      if (drain) cur = '0;
      else if (accepted) cur = (c < 3) ? instr_t'('0) : gen(c > 50);
      fl = (c >= 3 && !drain && $urandom_range(0, 9) == 0);
      RST = do_rst;
      ex_valid = cur.valid; ex_rd = cur.rd; ex_rt = cur.rt; ex_regwr = cur.regwr;
      ex_memrd = cur.memrd; ex_memwr = cur.memwr; ex_halt = cur.halt;
      ex_aluout = cur.alu; ex_store = cur.st; flush = fl;

      @(negedge CLK);
      // Memory responder: a request completes after its chosen latency
      memop = !m_halted && m_l.valid && (m_l.memrd || m_l.memwr);
      if (memop) begin
        dhit  = (m_cnt == 0);
        dload = (m_cnt == 0) ? m_l.ldata : $urandom;
      end else begin
        dhit  = 1'($urandom);
        dload = $urandom;
      end
      exp_stall = m_halted || (memop && m_cnt > 0);
      #1;

      got   = {mem_stall, dmem_ren, dmem_wen, dmem_addr, dmem_store, rd_mem, mem_rt,
               wr_mem, wm_mem, halt_out, stall_cycles};
      exp_v = {exp_stall, !m_halted && m_l.valid && m_l.memrd, !m_halted && m_l.valid && m_l.memwr,
               m_l.alu, m_l.st, m_l.rd, m_l.rt, m_l.valid && m_l.regwr, m_l.valid && m_l.memwr,
               m_halted, 16'(m_stalls)};
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL mem_side cyc=%0d got=%h exp=%h", cyc, got, exp_v);
      end
      if (c < 3) begin
        vectors++;
        if ({wb_valid, wb_regwr, wb_rd, wb_data} !== 39'd0) begin
          miscompares++;
          $display("FAIL reset_wb cyc=%0d got rd=%0d data=%h exp 0", cyc, wb_rd, wb_data);
        end
      end

      // Advance the model across the coming edge
      if (do_rst) begin
        m_l = '0; m_cnt = 0; m_stalls = 0; halt_wait = 0;
        m_halted = 1'b0; accepted = 1'b0;
      end else if (exp_stall) begin
        if (m_halted) halt_wait++;
        else begin
          if (m_stalls < 65535) m_stalls++;
          m_cnt--;
        end
        accepted = 1'b0;
      end else begin
        if (m_l.valid) begin
          e.due   = cyc + 1;
          e.rd    = m_l.rd;
          e.regwr = m_l.regwr & ~m_l.memwr;
          e.data  = m_l.memrd ? m_l.ldata : m_l.alu;
          sbq.push_back(e);
          if (m_l.halt) m_halted = 1'b1;
        end
        m_l = cur;
        m_l.valid = cur.valid & ~fl;
        m_l.regwr = cur.regwr & cur.valid & ~fl;
        m_l.memrd = cur.memrd & cur.valid & ~fl;
        m_l.memwr = cur.memwr & cur.valid & ~fl;
        m_l.halt  = cur.halt  & cur.valid & ~fl;
        m_cnt = int'(cur.lat);
        accepted = 1'b1;
      end

      @(posedge CLK);
      #1;
    end

    @(negedge CLK);
    #1;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got=%0d pending exp=0", sbq.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
